// File: rtl/rf_pkg.sv
// Shared register-file parameters, instruction-field types and the operand select helper
// used by the operand fetch stage and its scoreboard.
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xword_t;

  typedef struct packed {
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      rd_wen;
  } fetch_instr_t;

  // x0 always reads zero; a same-cycle writeback beats the (stale) register file value.
  function automatic xword_t select_operand(
    input reg_addr_t src,
    input logic      bypass,
    input xword_t    wb_data,
    input xword_t    rf_data
  );
    xword_t result;
    if (src == '0) begin
      result = '0;
    end else if (bypass) begin
      result = wb_data;
    end else begin
      result = rf_data;
    end
    return result;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set on issue,
// cleared on writeback, with set taking priority and register 0 never busy.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t look_addr1,
  input  reg_addr_t look_addr2,
  output logic      busy1,
  output logic      busy2
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  assign busy_next[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_busy
      logic set_hit;
      logic clr_hit;
      assign set_hit = set_en && (set_addr == reg_addr_t'(gi));
      assign clr_hit = clr_en && (clr_addr == reg_addr_t'(gi));
      assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy1 = busy_reg[look_addr1];
  assign busy2 = busy_reg[look_addr2];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: HOLD register waits for source hazards to resolve, then moves into
// the OUT register with operands read from the register file. Optional FETCH_BYPASS_EN.
module operand_fetch
  import rf_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      in_valid,
  output logic      in_ready,
  input  reg_addr_t in_rs1,
  input  reg_addr_t in_rs2,
  input  reg_addr_t in_rd,
  input  logic      in_rd_wen,
  output reg_addr_t rg_rd_addr1,
  output reg_addr_t rg_rd_addr2,
  input  xword_t    rg_rd_data1,
  input  xword_t    rg_rd_data2,
  input  logic      wb_valid,
  input  reg_addr_t wb_addr,
  input  xword_t    wb_data,
  output logic      out_valid,
  input  logic      out_ready,
  output xword_t    out_op1,
  output xword_t    out_op2,
  output reg_addr_t out_rd,
  output logic      out_rd_wen
);

  fetch_instr_t hold_reg;
  logic         hold_valid_reg;
  logic         out_valid_reg;
  xword_t       op1_reg;
  xword_t       op2_reg;
  reg_addr_t    out_rd_reg;
  logic         out_rd_wen_reg;

  logic   busy1;
  logic   busy2;
  logic   bypass1;
  logic   bypass2;
  logic   resolved1;
  logic   resolved2;
  logic   transfer;
  logic   accept;
  logic   set_en;
  xword_t op1_next;
  xword_t op2_next;

  assign rg_rd_addr1 = hold_valid_reg ? hold_reg.rs1 : '0;
  assign rg_rd_addr2 = hold_valid_reg ? hold_reg.rs2 : '0;

`ifdef FETCH_BYPASS_EN
  assign bypass1 = wb_valid && (wb_addr == hold_reg.rs1);
  assign bypass2 = wb_valid && (wb_addr == hold_reg.rs2);
`else
  // Without bypass a matching source waits for busy to clear, then reads the updated file.
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  assign resolved1 = (hold_reg.rs1 == '0) || !busy1 || bypass1;
  assign resolved2 = (hold_reg.rs2 == '0) || !busy2 || bypass2;

  assign transfer = hold_valid_reg && resolved1 && resolved2 && (!out_valid_reg || out_ready);
  assign in_ready = !hold_valid_reg || transfer;
  assign accept   = in_valid && in_ready;
  assign set_en   = transfer && hold_reg.rd_wen && (hold_reg.rd != '0);

  assign op1_next = select_operand(hold_reg.rs1, bypass1, wb_data, rg_rd_data1);
  assign op2_next = select_operand(hold_reg.rs2, bypass2, wb_data, rg_rd_data2);

  rf_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en     (set_en),
    .set_addr   (hold_reg.rd),
    .clr_en     (wb_valid),
    .clr_addr   (wb_addr),
    .look_addr1 (hold_reg.rs1),
    .look_addr2 (hold_reg.rs2),
    .busy1      (busy1),
    .busy2      (busy2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_reg <= 1'b0;
      hold_reg       <= '0;
    end else if (accept) begin
      hold_valid_reg <= 1'b1;
      hold_reg       <= '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, rd_wen: in_rd_wen};
    end else if (transfer) begin
      hold_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      op1_reg        <= '0;
      op2_reg        <= '0;
      out_rd_reg     <= '0;
      out_rd_wen_reg <= 1'b0;
    end else if (transfer) begin
      out_valid_reg  <= 1'b1;
      op1_reg        <= op1_next;
      op2_reg        <= op2_next;
      out_rd_reg     <= hold_reg.rd;
      out_rd_wen_reg <= hold_reg.rd_wen;
    end else if (out_ready) begin
      out_valid_reg  <= 1'b0;
      op1_reg        <= '0;
      op2_reg        <= '0;
      out_rd_reg     <= '0;
      out_rd_wen_reg <= 1'b0;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_op1    = op1_reg;
  assign out_op2    = op2_reg;
  assign out_rd     = out_rd_reg;
  assign out_rd_wen = out_rd_wen_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed hazard/backpressure/reset scenarios, then randomized
// traffic checked against an in-order architectural register model. Honors FETCH_BYPASS_EN.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [4:0]  rg_rd_addr1;
  logic [4:0]  rg_rd_addr2;
  logic [31:0] rg_rd_data1;
  logic [31:0] rg_rd_data2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_wen;

  operand_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd       (in_rd),
    .in_rd_wen   (in_rd_wen),
    .rg_rd_addr1 (rg_rd_addr1),
    .rg_rd_addr2 (rg_rd_addr2),
    .rg_rd_data1 (rg_rd_data1),
    .rg_rd_data2 (rg_rd_data2),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op1     (out_op1),
    .out_op2     (out_op2),
    .out_rd      (out_rd),
    .out_rd_wen  (out_rd_wen)
  );

  always #5 clk = ~clk;

  // Behavioural register file: asynchronous read, written by the writeback port.
  logic [31:0] rf [32];
  assign rg_rd_data1 = rf[rg_rd_addr1];
  assign rg_rd_data2 = rf[rg_rd_addr2];
  always @(posedge clk) if (wb_valid) rf[wb_addr] <= wb_data;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_rd     = '0;
    in_rd_wen = 1'b0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    out_ready = 1'b1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen);
    in_valid  = 1'b1;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_rd     = rd;
    in_rd_wen = wen;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] data;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        wb_q[$];
  logic [31:0] arch [32];
  logic [31:0] pending;

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = 32'h100 + r;
    rf[0] = 32'hFFFF_FFFF;
    rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33; rf[4] = 32'h44;

    // Reset state
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_rg_addr1", rg_rd_addr1, 0);
    check("rst_out_op1", out_op1, 0);
    check("rst_busy", dut.u_scoreboard.busy_reg, 0);

    // Basic fetch, one cycle after acceptance
    issue(5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    in_valid = 1'b0;
    check("basic_rg_addr1", rg_rd_addr1, 1);
    check("basic_rg_addr2", rg_rd_addr2, 2);
    tick();
    check("basic_out_valid", out_valid, 1);
    check("basic_op1", out_op1, 32'h11);
    check("basic_op2", out_op2, 32'h22);
    tick();
    check("basic_drained", out_valid, 0);

    // RAW hazard on r5 resolved by writeback
    issue(5'd0, 5'd0, 5'd5, 1'b1);
    tick();
    issue(5'd5, 5'd0, 5'd6, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    check("raw_stall_in_ready", in_ready, 0);
    check("raw_first_out", out_valid, 1);
    tick();
    check("raw_wait_out_valid", out_valid, 0);
    check("raw_wait_in_ready", in_ready, 0);
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hABCD;
    #1;
`ifdef FETCH_BYPASS_EN
    check("raw_bypass_in_ready", in_ready, 1);
    tick();
    wb_valid = 1'b0;
    check("raw_bypass_valid", out_valid, 1);
    check("raw_bypass_op1", out_op1, 32'hABCD);
`else
    check("raw_nobyp_in_ready", in_ready, 0);
    tick();
    wb_valid = 1'b0;
    check("raw_nobyp_wait", out_valid, 0);
    tick();
    check("raw_nobyp_valid", out_valid, 1);
    check("raw_nobyp_op1", out_op1, 32'hABCD);
`endif
    tick();

    // x0 sources read zero; rd=0 never marks busy
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check("x0_valid", out_valid, 1);
    check("x0_op1", out_op1, 0);
    check("x0_op2", out_op2, 0);
    check("x0_busy0", dut.u_scoreboard.busy_reg[0], 0);
    tick();

    // Backpressure: OUT held stable, HOLD keeps second instruction
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd10, 1'b0);
    tick();
    issue(5'd3, 5'd4, 5'd11, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_op1_stable", out_op1, 32'h11);
      check("bp_rd_stable", out_rd, 10);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    tick();
    check("bp_second_valid", out_valid, 1);
    check("bp_second_op1", out_op1, 32'h33);
    check("bp_second_op2", out_op2, 32'h44);
    tick();
    check("bp_empty", out_valid, 0);

    // Same-cycle set and clear on r7: set wins
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("sc_busy7_first", dut.u_scoreboard.busy_reg[7], 1);
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    tick();
    wb_valid = 1'b0;
    check("sc_busy7_set_wins", dut.u_scoreboard.busy_reg[7], 1);
    check("sc_out_rd", out_rd, 7);
    wb_valid = 1'b1; wb_addr = 5'd7;
    tick();
    wb_valid = 1'b0;
    check("sc_busy7_cleared", dut.u_scoreboard.busy_reg[7], 0);
    tick();

    // Reset during a stall on r9
    issue(5'd0, 5'd0, 5'd9, 1'b1);
    tick();
    issue(5'd9, 5'd0, 5'd12, 1'b0);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    check("rs_stalled", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    check("rs_out_valid", out_valid, 0);
    check("rs_busy", dut.u_scoreboard.busy_reg, 0);
    check("rs_in_ready", in_ready, 1);
    check("rs_out_rd", out_rd, 0);
    check("rs_out_rd_wen", out_rd_wen, 0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rs_release_in_ready", in_ready, 1);
    tick();
    check("rs_discarded", out_valid, 0);

    // Randomized traffic against the architectural model
    for (int r = 1; r < 32; r++) rf[r] = $urandom;
    do_reset();
    for (int r = 1; r < 32; r++) arch[r] = rf[r];
    arch[0] = 32'h0;
    pending = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = (cyc < 2500) && ($urandom_range(0, 3) != 0);
      in_rs1    = 5'($urandom_range(0, 7));
      in_rs2    = 5'($urandom_range(0, 7));
      in_rd     = 5'($urandom_range(0, 7));
      in_rd_wen = 1'($urandom_range(0, 1));
      if (in_rd_wen && in_rd != 0 && pending[in_rd]) in_rd_wen = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      wb_data   = $urandom;
      if (wb_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        wb_valid = 1'b1;
        wb_addr  = wb_q[0].rd;
        wb_data  = wb_q[0].data;
      end else begin
        wb_valid = 1'b0;
        wb_addr  = 5'($urandom_range(0, 31));
      end
      @(negedge clk);
      if (wb_valid) begin
        pending[wb_addr] = 1'b0;
        void'(wb_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_out", 1, 0);
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          check("rnd_op1", out_op1, e.op1);
          check("rnd_op2", out_op2, e.op2);
          check("rnd_rd", 32'(out_rd), 32'(e.rd));
          check("rnd_rd_wen", 32'(out_rd_wen), 32'(e.wen));
          $display("retire rd=%0d wen=%0d op1=%h op2=%h", out_rd, out_rd_wen, out_op1, out_op2);
          if (e.wen && e.rd != 0) wb_q.push_back(e);
        end
      end
      if (in_valid && in_ready) begin
        rec_t n;
        n.rd   = in_rd;
        n.wen  = in_rd_wen;
        n.op1  = (in_rs1 == 0) ? 32'h0 : arch[in_rs1];
        n.op2  = (in_rs2 == 0) ? 32'h0 : arch[in_rs2];
        n.data = $urandom;
        if (n.wen && n.rd != 0) begin
          arch[n.rd]    = n.data;
          pending[n.rd] = 1'b1;
        end
        exp_q.push_back(n);
      end
      @(posedge clk);
      #1;
    end
    check("rnd_drain_out", exp_q.size(), 0);
    check("rnd_drain_wb", wb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The ports SHALL be:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  block accepts the instruction
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_rd  in  5  destination register
- in_rd_wen  in  1  instruction writes in_rd
- rg_rd_addr1  out  5  register file read address 1
- rg_rd_addr2  out  5  register file read address 2
- rg_rd_data1  in  32  register file read data 1 (asynchronous read)
- rg_rd_data2  in  32  register file read data 2 (asynchronous read)
- wb_valid  in  1  writeback occurs this cycle; it is also the register file write enable
- wb_addr  in  5  writeback address
- wb_data  in  32  writeback data
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts the operands
- out_op1  out  32  operand 1
- out_op2  out  32  operand 2
- out_rd  out  5  destination register
- out_rd_wen  out  1  destination write enable

Function
REQ-003 The block SHALL contain a hold register (HOLD) and an output register (OUT), each with its own valid bit.
REQ-004 HOLD SHALL capture in_rs1, in_rs2, in_rd and in_rd_wen on a rising edge where in_valid && in_ready.
REQ-005 rg_rd_addr1 and rg_rd_addr2 SHALL be driven combinationally from the HOLD rs1 and rs2 fields; they SHALL be 0 when HOLD is empty.
REQ-006 A 32-bit scoreboard SHALL track pending writes: busy[r]=1 means an issued instruction will write register r.
REQ-007 A source SHALL be resolved when any of these holds:
- its address is 0;
- its busy bit is 0;
- (FETCH_BYPASS_EN only) wb_valid && wb_addr equals the source address.
REQ-008 HOLD SHALL transfer into OUT on a rising edge where HOLD is valid, both sources are resolved, and (OUT is empty or out_ready=1).
REQ-009 Operand selection SHALL be, in priority order:
- 0 when the source address is 0;
- wb_data when the bypass condition holds;
- otherwise rg_rd_data1 or rg_rd_data2.
REQ-010 in_ready SHALL equal (HOLD empty) or (the HOLD-to-OUT transfer occurs this cycle).
REQ-011 With no hazard, an instruction accepted at edge N SHALL present out_valid=1 after edge N+1; sustained throughput SHALL be 1 instruction per cycle.
REQ-012 out_valid SHALL be held, with OUT contents stable, until out_ready=1; OUT SHALL clear when out_ready=1 and no transfer occurs.
REQ-013 On transfer with rd_wen=1 and rd!=0, busy[rd] SHALL be set.
REQ-014 On wb_valid=1, busy[wb_addr] SHALL be cleared.
REQ-015 When a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-016 busy[0] SHALL always read 0.
REQ-017 A source hazard SHALL stall only HOLD; OUT continues to drain.

Reset
REQ-018 On reset assertion, HOLD valid, OUT valid, the whole scoreboard, out_op1, out_op2, out_rd and out_rd_wen SHALL clear to 0 immediately.
REQ-019 Immediately after reset, in_ready SHALL be 1.
REQ-020 A reset asserted mid-stall SHALL discard the held instruction.

Configuration
REQ-021 Macro FETCH_BYPASS_EN SHALL select writeback bypass.
- Defined: a source matching a same-cycle writeback resolves that cycle and takes wb_data.
- Undefined: the source waits until the edge that clears busy, then reads the register file on the following cycle, adding one stall cycle.

Structure
REQ-022 Package rf_pkg SHALL hold XLEN=32, REG_ADDR_W=5 and NUM_REGS=32.
REQ-023 The scoreboard SHALL be a sub-module named rf_scoreboard with ports:
- set enable and set address;
- clear enable and clear address;
- two lookup addresses and two busy results.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Reset, then issue rs1=1, rs2=2 with the register file returning 0x11 and 0x22 -> out_op1=0x11 and out_op2=0x22 one cycle after acceptance.
- Issue rd=5 (wen), then rs1=5 -> the second instruction stalls and in_ready=0. Then drive wb_valid, wb_addr=5, wb_data=0xABCD. With FETCH_BYPASS_EN: out_op1=0xABCD on the next edge. Without it: out_op1=0xABCD one cycle later.
- rs1=0, rs2=0 with the register file driving 0xFFFFFFFF -> out_op1=out_op2=0; an instruction with rd=0 and wen=1 leaves busy[0]=0.
- out_ready held 0 for 3 cycles with two instructions issued -> OUT stable, HOLD holds the second, in_ready=0; out_ready=1 -> both drain in order.
- Same-cycle wb clearing r7 and a transfer setting r7 -> busy[7]=1 afterward.
- Reset asserted during a stall on r9 -> out_valid=0, busy all 0, in_ready=1 on release.
